param_router: RTL and testbench
===============================

Name: param_router

Overview:
- Parametrised N-port to 1 packet-word router.
- Generalises the fixed 4-input, 8-bit router with these features:
  - configurable port count, data width and per-port buffering
  - fair round-robin arbitration
  - an output-side valid/ack handshake
- Sits between N producer DataPorts and a single downstream consumer.
- Replaces the hard-wired controller/datapath pair in the next design revision.

Parameters:
- NPORTS, 4: number of input ports (2..16).
- DW, 8: data word width in bits.
- DEPTH, 4: per-port FIFO depth in words (power of 2, ≥2).
- SW, $clog2(NPORTS) (min 1): width of source-port index, derived.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- inData  in  NPORTS*DW  input words; port i occupies bits [i*DW +: DW].
- request  in  NPORTS  request[i]=1 offers inData slice i this cycle.
- ready  out  NPORTS  ready[i]=1: port i FIFO can accept a word.
- output_port  out  DW  routed data word.
- out_valid  out  1  output_port/out_src hold a valid word.
- out_src  out  SW  index of the input port the word came from.
- out_ack  in  1  consumer accepts current word.

Behaviour:
- Reset (rst=1 at a clk edge):
  - all FIFOs empty; RR pointer=0; FSM=IDLE.
  - out_valid=0, output_port=0, out_src=0.
  - ready forced to 0 while rst=1.
  - ready becomes all-ones the cycle after rst deasserts.
  - Reset mid-transfer discards all buffered and held words without error.
- Input side:
  - ready[i] = ~full[i] & ~rst, combinational from the registered count only.
  - Push into FIFO i on an edge where request[i]&ready[i].
  - request while ready=0 is ignored (word dropped; producer must hold).
  - A pop of FIFO i in the same cycle does not raise ready[i] until the next cycle.
  - Simultaneous push and pop on a non-full FIFO: count unchanged.
- FIFO:
  - circular buffer, DEPTH entries.
  - read/write pointers $clog2(DEPTH) bits, wrap to 0 after DEPTH-1.
  - count $clog2(DEPTH)+1 bits.
  - full = (count==DEPTH); empty = (count==0).
- Arbiter:
  - round-robin over nonempty FIFOs, searching from port ptr upward with wrap to 0.
  - After granting port g, ptr <= (g+1) mod NPORTS.
  - ptr is unchanged when no grant.
- FSM, states IDLE and HOLD:
  - IDLE: if any FIFO nonempty, pop the winner, load output_port/out_src, out_valid<=1, go to HOLD; else stay.
  - HOLD: output_port/out_src stable while out_ack=0.
  - HOLD on out_ack=1 with some FIFO nonempty: pop the next winner in the same edge (back-to-back, no bubble), stay HOLD.
  - HOLD on out_ack=1 with all empty: out_valid<=0, go to IDLE; output_port retains its last value.
  - out_ack in IDLE is ignored.
- Latency:
  - A word pushed at edge k into an idle router with all FIFOs empty gives out_valid=1 after edge k+1.
  - Throughput is 1 word/cycle while out_ack is held high.
- Ordering: per-port FIFO order preserved; no cross-port ordering guarantee beyond RR fairness.

Decomposition:
- Shared package router_pkg holds:
  - state encoding constants ST_IDLE=1'b0, ST_HOLD=1'b1
  - default NPORTS/DW/DEPTH values
  - a clog2 helper function
- Sub-module router_fifo (params DW, DEPTH):
  - ports clk, rst, push, din, pop, dout, full, empty
  - dout is show-ahead, valid whenever ~empty
  - instantiated NPORTS times via generate.
- Arbiter and FSM stay in param_router.

Test Plan:
- Reset then idle (defaults):
  - drive rst=1 for 2 cycles → ready=4'b0000, out_valid=0, output_port=8'h00.
  - after release → ready=4'b1111.
- Single word:
  - request1 with inData slice 1=8'hA5 for one cycle, out_ack=1.
  - → out_valid=1 one edge after the push, output_port=8'hA5, out_src=1.
  - then out_valid=0 the following edge.
- Round robin:
  - hold out_ack=0, push one word into each of ports 0..3 (8'h10,8'h21,8'h32,8'h43), then set out_ack=1.
  - → out_src sequence 0,1,2,3 on consecutive cycles, no bubble.
- Full/backpressure:
  - out_ack=0, push 5 words into port 2 → ready[2]=0 after the 4th push; 5th word (8'hFF) not stored.
  - then out_ack=1 → exactly 4 words drained in order.
  - ready[2]=1 the cycle after the first pop.
- Fairness under contention:
  - ports 0 and 3 continuously requesting with out_ack=1 → grants alternate 0,3,0,3.
  - port 0 never wins twice in a row while port 3 is nonempty.
- Reset mid-operation:
  - with 3 words buffered and out_valid=1, assert rst for 1 cycle → out_valid=0, all FIFOs empty.
  - no stale word appears after release.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the parametrised N-to-1 packet-word router.
package router_pkg;

    // Default configuration: the original 4-port, 8-bit router with 4-word buffers.
    localparam int DEF_NPORTS = 4;
    localparam int DEF_DW     = 8;
    localparam int DEF_DEPTH  = 4;

    // Output-side FSM states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Ceiling log2 that can be used in parameter expressions; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage : router_pkg

// File: rtl/router_fifo.sv
// Per-port circular FIFO with show-ahead output (dout valid whenever ~empty).
module router_fifo
    import router_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    // Full/empty decode from the registered count only, so ready never sees a same-cycle pop.
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];

    // Storage array write port.
    // NOTE: the storage array has no reset; the count alone defines which entries are live,
    // and leaving it unreset lets it map onto plain RAM/register-file cells.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    // NOTE: sequential state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule : router_fifo

// File: rtl/param_router.sv
// Parametrised N-port to 1 router: per-port FIFOs, round-robin arbiter and a
// two-state output FSM driving a valid/ack handshake to a single consumer.
module param_router
    import router_pkg::*;
#(
    parameter int NPORTS = DEF_NPORTS,
    parameter int DW     = DEF_DW,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int SW     = (clog2(NPORTS) < 1) ? 1 : clog2(NPORTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NPORTS*DW-1:0] inData,
    input  logic [NPORTS-1:0]    request,
    output logic [NPORTS-1:0]    ready,
    output logic [DW-1:0]        output_port,
    output logic                 out_valid,
    output logic [SW-1:0]        out_src,
    input  logic                 out_ack
);

    logic [NPORTS-1:0] fifo_full;
    logic [NPORTS-1:0] fifo_empty;
    logic [NPORTS-1:0] fifo_push;
    logic [NPORTS-1:0] fifo_pop;
    logic [DW-1:0]     fifo_dout [NPORTS];

    logic [SW-1:0]     rr_ptr_q;
    logic [SW-1:0]     rr_ptr_d;
    logic [SW-1:0]     grant_idx;
    logic              grant_valid;
    logic [SW:0]       cand_sum;
    logic [SW-1:0]     cand_idx;
    logic              do_pop;

    state_e            state_q;
    logic [DW-1:0]     out_data_q;
    logic [SW-1:0]     out_src_q;
    logic              out_valid_q;

    // Input acceptance: ready is held low during reset, and a word offered while not ready is dropped.
    assign ready     = ~fifo_full & {NPORTS{~rst}};
    assign fifo_push = request & ready;

    for (genvar g = 0; g < NPORTS; g++) begin : g_port
        router_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (fifo_push[g]),
            .din   (inData[g*DW +: DW]),
            .pop   (fifo_pop[g]),
            .dout  (fifo_dout[g]),
            .full  (fifo_full[g]),
            .empty (fifo_empty[g])
        );
    end

    // Round-robin search: first nonempty port starting at rr_ptr_q, wrapping past NPORTS-1.
    // NOTE: every variable gets a default at the top of the block so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        cand_idx    = '0;
        for (int k = 0; k < NPORTS; k++) begin
            cand_sum = {1'b0, rr_ptr_q} + (SW+1)'(k);
            if (cand_sum >= (SW+1)'(NPORTS)) begin
                cand_sum = cand_sum - (SW+1)'(NPORTS);
            end
            cand_idx = cand_sum[SW-1:0];
            if (!grant_valid && !fifo_empty[cand_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Pop the winner whenever the output register is free or being acknowledged this edge.
    always_comb begin
        do_pop   = grant_valid & ~rst & ((state_q == ST_IDLE) | out_ack);
        fifo_pop = '0;
        fifo_pop[grant_idx] = do_pop;
        rr_ptr_d = (grant_idx == SW'(NPORTS - 1)) ? '0 : grant_idx + 1'b1;
    end

    // Output FSM: IDLE waits for any buffered word, HOLD presents it until acknowledged.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_valid) begin
                        out_data_q  <= fifo_dout[grant_idx];
                        out_src_q   <= grant_idx;
                        out_valid_q <= 1'b1;
                        rr_ptr_q    <= rr_ptr_d;
                        state_q     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ack) begin
                        if (grant_valid) begin
                            out_data_q <= fifo_dout[grant_idx];
                            out_src_q  <= grant_idx;
                            rr_ptr_q   <= rr_ptr_d;
                        end else begin
                            out_valid_q <= 1'b0;
                            state_q     <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign output_port = out_data_q;
    assign out_src     = out_src_q;
    assign out_valid   = out_valid_q;

endmodule : param_router

// File: tb/tb_param_router.sv
// Self-checking bench for param_router: directed scenarios plus randomized
// traffic, all compared against a queue-based reference model.
module tb_param_router;

    localparam int NPORTS = 4;
    localparam int DW     = 8;
    localparam int DEPTH  = 4;
    localparam int SW     = 2;

    logic                 clk;
    logic                 rst;
    logic [NPORTS*DW-1:0] inData;
    logic [NPORTS-1:0]    request;
    logic [NPORTS-1:0]    ready;
    logic [DW-1:0]        output_port;
    logic                 out_valid;
    logic [SW-1:0]        out_src;
    logic                 out_ack;

    param_router #(
        .NPORTS (NPORTS),
        .DW     (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inData      (inData),
        .request     (request),
        .ready       (ready),
        .output_port (output_port),
        .out_valid   (out_valid),
        .out_src     (out_src),
        .out_ack     (out_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: one queue per port plus the word currently on the output.
    logic [DW-1:0] mq [NPORTS][$];
    logic          m_valid;
    logic [DW-1:0] m_data;
    int            m_src;
    int            m_ptr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic set_word(input int port, input logic [DW-1:0] val);
        inData[port*DW +: DW] = val;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        bit can_take [NPORTS];
        int w;
        if (rst) begin
            for (int i = 0; i < NPORTS; i++) mq[i].delete();
            m_valid = 1'b0;
            m_data  = '0;
            m_src   = 0;
            m_ptr   = 0;
            return;
        end
        for (int i = 0; i < NPORTS; i++) can_take[i] = (mq[i].size() < DEPTH);
        if (!m_valid || out_ack) begin
            w = -1;
            for (int k = 0; k < NPORTS; k++) begin
                int p;
                p = (m_ptr + k) % NPORTS;
                if (w < 0 && mq[p].size() > 0) w = p;
            end
            if (w >= 0) begin
                m_data  = mq[w].pop_front();
                m_src   = w;
                m_valid = 1'b1;
                m_ptr   = (w + 1) % NPORTS;
            end else begin
                m_valid = 1'b0;
            end
        end
        for (int i = 0; i < NPORTS; i++) begin
            if (request[i] && can_take[i]) mq[i].push_back(inData[i*DW +: DW]);
        end
    endtask

    // One clock: update the model at the edge, then compare all outputs 1 time unit later.
    task automatic step();
        logic [NPORTS-1:0] exp_ready;
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < NPORTS; i++) exp_ready[i] = !rst && (mq[i].size() < DEPTH);
        check("ready", 32'(ready), 32'(exp_ready));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("output_port", 32'(output_port), 32'(m_data));
        check("out_src", 32'(out_src), 32'(m_src));
    endtask

    // Safety net in case the clock or a task ever stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    int          prev_src;
    logic        prev_valid;
    int          repeat0;
    logic [7:0]  drain_exp [4];

    initial begin
        rst     = 1'b1;
        request = '0;
        inData  = '0;
        out_ack = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        m_src   = 0;
        m_ptr   = 0;

        // Reset then idle.
        step();
        step();
        check("rst_ready", 32'(ready), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_data", 32'(output_port), 32'h00);
        rst = 1'b0;
        step();
        check("post_rst_ready", 32'(ready), 32'hF);

        // Single word from port 1.
        out_ack = 1'b1;
        request = 4'b0010;
        set_word(1, 8'hA5);
        step();
        check("single_not_yet", 32'(out_valid), 32'h0);
        request = '0;
        step();
        check("single_valid", 32'(out_valid), 32'h1);
        check("single_data", 32'(output_port), 32'hA5);
        check("single_src", 32'(out_src), 32'h1);
        step();
        check("single_done", 32'(out_valid), 32'h0);
        check("single_retain", 32'(output_port), 32'hA5);

        // Round robin from a fresh pointer.
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ack = 1'b0;
        request = 4'b1111;
        set_word(0, 8'h10); set_word(1, 8'h21); set_word(2, 8'h32); set_word(3, 8'h43);
        step();
        request = '0;
        step();
        check("rr_src0", 32'(out_src), 32'h0);
        check("rr_data0", 32'(output_port), 32'h10);
        step();
        check("rr_hold_stable", 32'(output_port), 32'h10);
        out_ack = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            check("rr_valid", 32'(out_valid), 32'h1);
            check("rr_src", 32'(out_src), 32'(i));
        end
        step();
        check("rr_end", 32'(out_valid), 32'h0);

        // Full / backpressure on port 2 while the output holds a word from port 0.
        out_ack = 1'b0;
        request = 4'b0001;
        set_word(0, 8'h55);
        step();
        request = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            set_word(2, (i == 4) ? 8'hFF : 8'(i + 1));
            step();
            if (i == 3) check("full_ready2", 32'(ready[2]), 32'h0);
        end
        request = '0;
        out_ack = 1'b1;
        drain_exp[0] = 8'h01; drain_exp[1] = 8'h02; drain_exp[2] = 8'h03; drain_exp[3] = 8'h04;
        for (int i = 0; i < 4; i++) begin
            step();
            check("drain_data", 32'(output_port), 32'(drain_exp[i]));
            check("drain_src", 32'(out_src), 32'h2);
            if (i == 0) check("ready2_after_pop", 32'(ready[2]), 32'h1);
        end
        step();
        check("drain_no_ff", 32'(out_valid), 32'h0);

        // Fairness: ports 0 and 3 always requesting.
        out_ack    = 1'b1;
        request    = 4'b1001;
        repeat0    = 0;
        prev_valid = 1'b0;
        prev_src   = -1;
        for (int i = 0; i < 16; i++) begin
            set_word(0, 8'($urandom));
            set_word(3, 8'($urandom));
            step();
            if (out_valid && prev_valid && out_src == 0 && prev_src == 0) repeat0++;
            prev_valid = out_valid;
            prev_src   = out_src;
        end
        check("fair_no_repeat0", 32'(repeat0), 32'h0);
        request = '0;

        // Reset mid-operation.
        out_ack = 1'b0;
        request = 4'b1111;
        for (int i = 0; i < NPORTS; i++) set_word(i, 8'($urandom));
        step();
        request = '0;
        step();
        check("mid_valid_before", 32'(out_valid), 32'h1);
        rst = 1'b1;
        step();
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_ready", 32'(ready), 32'h0);
        rst     = 1'b0;
        out_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mid_no_stale", 32'(out_valid), 32'h0);
        end

        // Randomized traffic with occasional reset.
        for (int c = 0; c < 1500; c++) begin
            request = 4'($urandom);
            for (int i = 0; i < NPORTS; i++) set_word(i, 8'($urandom));
            out_ack = ($urandom_range(0, 3) != 0);
            rst     = ($urandom_range(0, 99) == 0);
            step();
        end
        rst     = 1'b0;
        request = '0;
        out_ack = 1'b1;
        for (int i = 0; i < 20; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_param_router
